// File: rtl/julia_dispatch.sv
// Raster-order pixel job dispatcher: hands each pixel to an idle Julia core
// (round-robin) and pulses frame_done once every issued job has been retired.
module julia_dispatch #(
  parameter int          NUM_JULIA = 16,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter logic [31:0] FB_BASE   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_JULIA-1:0] retire,
  output logic [NUM_JULIA-1:0] go,
  output logic [15:0]          job_x,
  output logic [15:0]          job_y,
  output logic [31:0]          job_addr,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int              RR_W    = (NUM_JULIA > 1) ? $clog2(NUM_JULIA) : 1;
  localparam logic [15:0]     X_LAST  = 16'(SCREEN_W - 1);
  localparam logic [15:0]     Y_LAST  = 16'(SCREEN_H - 1);
  localparam logic [RR_W-1:0] RR_INIT = RR_W'(NUM_JULIA - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [NUM_JULIA-1:0] owned, owned_kept, grant_oh;
  logic [RR_W-1:0]      rr, grant_idx;
  logic                 grant_ok, issue, last_pixel;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise paths that skip the assignment infer a latch.
  always_comb begin
    grant_idx = rr;
    grant_ok  = 1'b0;
    // Scan from farthest to nearest so the first free core after rr wins.
    for (int i = NUM_JULIA; i >= 1; i--) begin
      if (!owned[(int'(rr) + i) % NUM_JULIA]) begin
        grant_idx = RR_W'((int'(rr) + i) % NUM_JULIA);
        grant_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < NUM_JULIA; k++) begin
      grant_oh[k] = (grant_idx == RR_W'(k));
    end
  end

  assign issue      = (state == S_ISSUE) && grant_ok;
  assign go         = issue ? grant_oh : '0;
  assign owned_kept = owned & ~retire;
  assign last_pixel = (job_x == X_LAST) && (job_y == Y_LAST);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (issue && last_pixel) state_nxt = S_DRAIN;
      // Same-cycle retires count, so the last retire can close the frame.
      S_DRAIN: if (owned_kept == '0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      owned    <= '0;
      rr       <= RR_INIT;
      job_x    <= '0;
      job_y    <= '0;
      job_addr <= FB_BASE;
    end else begin
      state <= state_nxt;
      owned <= owned_kept | go;
      if (issue) rr <= grant_idx;

      if (state == S_IDLE && start) begin
        job_x    <= '0;
        job_y    <= '0;
        job_addr <= FB_BASE;
      end else if (issue) begin
        job_addr <= job_addr + 32'd4;
        if (job_x == X_LAST) begin
          job_x <= '0;
          job_y <= job_y + 16'd1;
        end else begin
          job_x <= job_x + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_julia_dispatch.sv
// Bench for julia_dispatch: a frame-level reference model (pixel index,
// ownership set, last grant) runs in lockstep with directed and random stimulus.
module tb_julia_dispatch;

  localparam int          NJ     = 4;
  localparam int          W      = 4;
  localparam int          H      = 2;
  localparam int          TOTAL  = W * H;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] S_BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [NJ-1:0] retire, go;
  logic [15:0]   job_x, job_y;
  logic [31:0]   job_addr;
  logic          busy, frame_done;

  logic          rst_s, start_s;
  logic [NJ-1:0] retire_s, go_s;
  logic [15:0]   job_x_s, job_y_s;
  logic [31:0]   job_addr_s;
  logic          busy_s, frame_done_s;

  julia_dispatch #(.NUM_JULIA(NJ), .SCREEN_W(W), .SCREEN_H(H), .FB_BASE(BASE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .retire(retire), .go(go),
    .job_x(job_x), .job_y(job_y), .job_addr(job_addr),
    .busy(busy), .frame_done(frame_done)
  );

  julia_dispatch #(.NUM_JULIA(NJ), .SCREEN_W(1), .SCREEN_H(1), .FB_BASE(S_BASE)) u_small (
    .clk(clk), .rst(rst_s), .start(start_s), .retire(retire_s), .go(go_s),
    .job_x(job_x_s), .job_y(job_y_s), .job_addr(job_addr_s),
    .busy(busy_s), .frame_done(frame_done_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 issuing, 2 draining, 3 done.
  int            m_phase, m_pix, m_last, cyc;
  logic [NJ-1:0] m_owned, hold;
  int            due [NJ];
  bit            rand_dly;
  int            go_hist[$];
  int            fd_cnt;

  task automatic model_reset();
    m_phase = 0;
    m_pix   = 0;
    m_owned = '0;
    m_last  = NJ - 1;
    for (int k = 0; k < NJ; k++) due[k] = -1;
  endtask

  function automatic int pick();
    for (int i = 1; i <= NJ; i++) begin
      int k;
      k = (m_last + i) % NJ;
      if (!m_owned[k]) return k;
    end
    return -1;
  endfunction

  function automatic int dly();
    return rand_dly ? int'($urandom_range(1, 6)) : 3;
  endfunction

  // One clock cycle: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic step(input bit st, input logic [NJ-1:0] extra);
    logic [NJ-1:0] ret, exp_go;
    int g;
    ret = extra;
    for (int k = 0; k < NJ; k++)
      if (due[k] == cyc && !hold[k]) ret[k] = 1'b1;
    start  = st;
    retire = ret;
    #1;
    if (rst) model_reset();
    g = (m_phase == 1) ? pick() : -1;
    exp_go = '0;
    if (g >= 0) exp_go[g] = 1'b1;
    check("go", go, exp_go);
    check("busy", busy, m_phase != 0);
    check("frame_done", frame_done, m_phase == 3);
    check("job_x", job_x, 32'(m_pix % W));
    check("job_y", job_y, 32'(m_pix / W));
    check("job_addr", job_addr, BASE + 32'(4 * m_pix));
    if (frame_done) fd_cnt++;
    for (int k = 0; k < NJ; k++)
      if (go[k]) go_hist.push_back(k);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_owned = m_owned & ~ret;
      case (m_phase)
        0: if (st) begin m_phase = 1; m_pix = 0; end
        1: if (g >= 0) begin
             m_owned[g] = 1'b1;
             m_last     = g;
             due[g]     = cyc + dly();
             m_pix++;
             if (m_pix == TOTAL) m_phase = 2;
           end
        2: if (m_owned == '0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to_idle(input int max);
    int n;
    n = 0;
    while (m_phase != 0 && n < max) begin
      step(1'b0, '0);
      n++;
    end
    if (m_phase != 0) check("frame_timeout", 32'(m_phase), 32'd0);
  endtask

  task automatic run_until_phase(input int p, input int max);
    int n;
    n = 0;
    while (m_phase != p && n < max) begin
      step(1'b0, '0);
      n++;
    end
    if (m_phase != p) check("phase_timeout", 32'(m_phase), 32'(p));
  endtask

  initial begin
    int cnt2;
    rst = 1'b1; start = 1'b0; retire = '0;
    rst_s = 1'b1; start_s = 1'b0; retire_s = '0;
    hold = '0; rand_dly = 1'b0; cyc = 0; fd_cnt = 0;
    model_reset();
    @(negedge clk);

    // Single-pixel frame on the small instance.
    check("s_rst_go", go_s, 0);
    check("s_rst_busy", busy_s, 0);
    check("s_rst_addr", job_addr_s, S_BASE);
    rst_s = 1'b0; start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    check("s_go", go_s, 1);
    check("s_addr", job_addr_s, S_BASE);
    check("s_x", job_x_s, 0);
    check("s_y", job_y_s, 0);
    check("s_busy", busy_s, 1);
    @(negedge clk);
    check("s_drain_go", go_s, 0);
    check("s_drain_fd", frame_done_s, 0);
    @(negedge clk);
    check("s_drain_busy", busy_s, 1);
    retire_s = 1;
    @(negedge clk); retire_s = '0;
    check("s_done_fd", frame_done_s, 1);
    @(negedge clk);
    check("s_idle_fd", frame_done_s, 0);
    check("s_idle_busy", busy_s, 0);

    // Main instance reset values.
    step(1'b0, '0);
    check("rst_go", go, 0);
    check("rst_addr", job_addr, BASE);
    rst = 1'b0;

    // Fixed 3-cycle retire: strict rotation, one frame_done.
    rand_dly = 1'b0; go_hist.delete(); fd_cnt = 0;
    step(1'b1, '0);
    run_to_idle(100);
    check("s1_gos", go_hist.size(), TOTAL);
    for (int i = 0; i < go_hist.size() && i < TOTAL; i++)
      check($sformatf("s1_grant%0d", i), go_hist[i], i % NJ);
    check("s1_fd_cnt", fd_cnt, 1);

    // Core 2 never retired until the frame is draining.
    rand_dly = 1'b1; hold = 4'b0100; go_hist.delete();
    step(1'b1, '0);
    run_until_phase(2, 200);
    repeat (5) step(1'b0, '0);
    check("hold_fd", frame_done, 0);
    check("hold_busy", busy, 1);
    cnt2 = 0;
    foreach (go_hist[i]) if (go_hist[i] == 2) cnt2++;
    check("hold_core2_issues", cnt2, 1);
    hold = '0; due[2] = cyc;
    run_to_idle(50);

    // All cores owned with no retires: issue stalls, then retire[3] frees core 3.
    rand_dly = 1'b0; hold = '1;
    step(1'b1, '0);
    repeat (4) step(1'b0, '0);
    repeat (10) step(1'b0, '0);
    check("stall_go", go, 0);
    check("stall_x", job_x, 0);
    check("stall_y", job_y, 1);
    hold = 4'b0111; due[3] = cyc;
    step(1'b0, '0);
    check("stall_go3", go, 4'b1000);
    hold = '0;
    for (int k = 0; k < 3; k++) due[k] = cyc;
    run_to_idle(100);

    // start ignored in ISSUE and DRAIN; honoured again in IDLE.
    rand_dly = 1'b1;
    step(1'b1, '0);
    step(1'b1, '0);
    run_until_phase(2, 200);
    step(1'b1, '0);
    run_to_idle(100);
    step(1'b1, '0);
    check("restart_x", job_x, 0);
    check("restart_y", job_y, 0);
    check("restart_addr", job_addr, BASE);
    check("restart_busy", busy, 1);
    run_to_idle(100);

    // Reset mid-frame at pixel 5, stray retire, then a clean start.
    while (m_pix < 5 && m_phase != 2) step(1'b0, '0);
    if (m_phase == 0) step(1'b1, '0);
    while (m_pix < 5) step(1'b0, '0);
    rst = 1'b1;
    step(1'b0, '0);
    check("mid_rst_go", go, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x", job_x, 0);
    check("mid_rst_addr", job_addr, BASE);
    rst = 1'b0;
    step(1'b0, 4'b0010);
    step(1'b1, '0);
    check("post_rst_go", go, 4'b0001);
    check("post_rst_x", job_x, 0);
    run_to_idle(100);

    // Random traffic: random starts, stray retires, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      bit st;
      logic [NJ-1:0] extra;
      if (m_phase == 0) rand_dly = $urandom_range(0, 1) == 1;
      st    = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      extra = ($urandom_range(0, 7) == 0) ? NJ'($urandom) : '0;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        step(1'b0, '0);
        rst = 1'b0;
      end
      step(st, extra);
    end
    run_to_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
